// File: rtl/br_input_fetch.sv
// br_input_fetch: walks a byte range of the branch input data memory through a
// combinational read port, packs PACK consecutive bytes per word (first byte in
// the LSB lane) and streams the words out through a small valid/ready FIFO.
// Optional feature macro: BR_SIGN_CONVERT_EN inverts bit7 of every byte before
// packing, turning offset-binary samples into two's-complement.
module br_input_fetch #(
  parameter int PACK       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [15:0]       base_addr_i,
  input  logic [11:0]       num_words_i,
  output logic [15:0]       mem_addr_o,
  input  logic [7:0]        mem_data_i,
  output logic              out_valid_o,
  output logic [PACK*8-1:0] out_data_o,
  output logic              out_last_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam int IW = $clog2(PACK);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(PACK - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [IW-1:0]       byte_idx;
  logic [11:0]         words_left;
  logic [PACK*8-1:0]   partial;
  logic [PACK*8-1:0]   pack_word;
  logic [7:0]          fetch_byte;
  logic                fetch;
  logic                push;
  logic                push_last;
  logic                pop;

  logic [PACK*8-1:0]   fifo_data [FIFO_DEPTH];
  logic                fifo_last [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;

`ifdef BR_SIGN_CONVERT_EN
  assign fetch_byte = {~mem_data_i[7], mem_data_i[6:0]};
`else
  assign fetch_byte = mem_data_i;
`endif

  // A byte is fetched only while the registered FIFO occupancy leaves room,
  // so a full FIFO freezes the address and the partial word.
  assign fetch     = (state == FETCH) && (count < DEPTH_C);
  assign push      = fetch && (byte_idx == LAST_IDX);
  assign push_last = (words_left == 12'd1);
  assign pop       = out_valid_o && out_ready_i;

  assign out_valid_o = (count != '0);
  assign out_data_o  = fifo_data[rd_ptr];
  assign out_last_o  = out_valid_o && fifo_last[rd_ptr];
  assign busy_o      = (state == FETCH) || (state == DRAIN);
  assign done_o      = (state == DONE);

  // Merge the byte arriving this cycle into its lane of the partially built word.
  always_comb begin
    pack_word = partial;
    pack_word[byte_idx*8 +: 8] = fetch_byte;
  end

  // State register; reset aborts any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Job sequencing: an empty job skips straight to the completion pulse, and
  // DRAIN waits for the downstream to empty the FIFO before reporting done.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_next = (num_words_i == 12'd0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (push && push_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (count == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Address walker and byte packer: loads the job on start, then advances one
  // byte per fetch, wrapping the 16-bit address naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_o <= 16'd0;
      byte_idx   <= '0;
      words_left <= 12'd0;
      partial    <= '0;
    end else begin
      if ((state == IDLE) && start_i) begin
        mem_addr_o <= base_addr_i;
        byte_idx   <= '0;
        words_left <= num_words_i;
      end else if (fetch) begin
        mem_addr_o <= mem_addr_o + 16'd1;
        partial    <= pack_word;
        if (push) begin
          byte_idx   <= '0;
          words_left <= words_left - 12'd1;
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end
    end
  end

  // Output FIFO: simultaneous push and pop both take effect with the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= pack_word;
        fifo_last[wr_ptr] <= push_last;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_br_input_fetch.sv
// Testbench for br_input_fetch (PACK=4, FIFO_DEPTH=4) with a 64 KiB memory
// image and a word-level reference model built from plain address arithmetic.
module tb_br_input_fetch;

  localparam int PACK = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [15:0] base_addr_i;
  logic [11:0] num_words_i;
  logic [15:0] mem_addr_o;
  logic [7:0]  mem_data_i;
  logic        out_valid_o;
  logic [31:0] out_data_o;
  logic        out_last_o;
  logic        out_ready_i;
  logic        busy_o;
  logic        done_o;

  logic [7:0]  mem [0:65535];
  logic [32:0] rx [$];
  int          checks = 0;
  int          errors = 0;
  int          doneCount = 0;
  int          validSeen = 0;
  logic        randomReady = 1'b0;
  logic        prevHold = 1'b0;
  logic [31:0] prevData;
  logic        prevLast;

  br_input_fetch #(.PACK(4), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .num_words_i (num_words_i),
    .mem_addr_o  (mem_addr_o),
    .mem_data_i  (mem_data_i),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .out_ready_i (out_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Combinational memory read port.
  assign mem_data_i = mem[mem_addr_o];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] convByte(input logic [7:0] b);
`ifdef BR_SIGN_CONVERT_EN
    return b ^ 8'h80;
`else
    return b;
`endif
  endfunction

  // Word k of a job is the PACK bytes starting at base + PACK*k, modulo 64 KiB.
  function automatic logic [31:0] expWord(input logic [15:0] base, input int k);
    logic [31:0] w;
    logic [15:0] a;
    for (int j = 0; j < PACK; j++) begin
      a = 16'((int'(base) + PACK * k + j) % 65536);
      w[j*8 +: 8] = convByte(mem[a]);
    end
    return w;
  endfunction

  // Monitor: records transfers and pulses, and checks the head stays stable while stalled.
  always @(negedge clk) begin
    if (rst) begin
      prevHold = 1'b0;
    end else begin
      if (prevHold && out_valid_o) begin
        checkOutput("hold_data", {32'd0, out_data_o}, {32'd0, prevData});
        checkOutput("hold_last", {63'd0, out_last_o}, {63'd0, prevLast});
      end
      if (out_valid_o && out_ready_i) rx.push_back({out_last_o, out_data_o});
      if (done_o) doneCount++;
      if (out_valid_o) validSeen++;
      prevHold = out_valid_o && !out_ready_i;
      prevData = out_data_o;
      prevLast = out_last_o;
    end
  end

  task automatic applyStimulus(input logic [15:0] base, input logic [11:0] num);
    base_addr_i = base;
    num_words_i = num;
    start_i     = 1'b1;
    @(posedge clk); #1;
    start_i     = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int c = 0;
    int d0 = doneCount;
    while (doneCount == d0 && c < budget) begin
      @(posedge clk); #1;
      if (randomReady) out_ready_i = 1'($urandom_range(0, 1));
      c++;
    end
    checkOutput("done_timeout", {63'd0, doneCount > d0}, 64'd1);
    randomReady = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic compareJob(input logic [15:0] base, input int n);
    checkOutput("word_count", 64'(rx.size()), 64'(n));
    for (int k = 0; k < n && k < rx.size(); k++) begin
      checkOutput($sformatf("word%0d_data", k), {32'd0, rx[k][31:0]}, {32'd0, expWord(base, k)});
      checkOutput($sformatf("word%0d_last", k), {63'd0, rx[k][32]}, {63'd0, k == n - 1});
    end
    rx.delete();
  endtask

  initial begin
    int d0;
    int v0;
    logic [15:0] rb;
    int rn;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) mem[i] = 8'h80;
    mem[16'h40] = 8'h59; mem[16'h41] = 8'h4F; mem[16'h42] = 8'hCD; mem[16'h43] = 8'h5D;
    mem[16'h44] = 8'h16; mem[16'h45] = 8'h16; mem[16'h46] = 8'h5C; mem[16'h47] = 8'h6F;

    rst = 1'b1;
    start_i = 1'b0;
    base_addr_i = 16'd0;
    num_words_i = 12'd0;
    out_ready_i = 1'b1;
    #3;
    checkOutput("reset_addr", {48'd0, mem_addr_o}, 64'd0);
    checkOutput("reset_valid", {63'd0, out_valid_o}, 64'd0);
    checkOutput("reset_data", {32'd0, out_data_o}, 64'd0);
    checkOutput("reset_last", {63'd0, out_last_o}, 64'd0);
    checkOutput("reset_busy", {63'd0, busy_o}, 64'd0);
    checkOutput("reset_done", {63'd0, done_o}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Two-word job with continuous ready: latency, values, last flag, single done pulse.
    $display("[TB] job base=0040 num=2");
    d0 = doneCount;
    applyStimulus(16'h0040, 12'd2);
    checkOutput("t1_addr_t0", {48'd0, mem_addr_o}, 64'h40);
    checkOutput("t1_busy", {63'd0, busy_o}, 64'd1);
    checkOutput("t1_valid_t0", {63'd0, out_valid_o}, 64'd0);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("t1_valid_t%0d", i), {63'd0, out_valid_o}, {63'd0, i == 4});
    end
    waitDone(100);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t1_done_pulses", 64'(doneCount - d0), 64'd1);
`ifdef BR_SIGN_CONVERT_EN
    if (rx.size() == 2) begin
      checkOutput("t1_word0", {32'd0, rx[0][31:0]}, 64'hDD4DCFD9);
      checkOutput("t1_word1", {32'd0, rx[1][31:0]}, 64'hEFDC9696);
    end
`else
    if (rx.size() == 2) begin
      checkOutput("t1_word0", {32'd0, rx[0][31:0]}, 64'h5DCD4F59);
      checkOutput("t1_word1", {32'd0, rx[1][31:0]}, 64'h6F5C1616);
    end
`endif
    compareJob(16'h0040, 2);

    // Offset-binary zero samples.
    $display("[TB] job base=0000 num=1");
    applyStimulus(16'h0000, 12'd1);
    waitDone(100);
`ifdef BR_SIGN_CONVERT_EN
    if (rx.size() == 1) checkOutput("t2_word", {32'd0, rx[0][31:0]}, 64'h00000000);
`else
    if (rx.size() == 1) checkOutput("t2_word", {32'd0, rx[0][31:0]}, 64'h80808080);
`endif
    compareJob(16'h0000, 1);

    // Backpressure: FIFO fills to 4 words and the address freezes.
    $display("[TB] job base=0040 num=8 with stalled output");
    out_ready_i = 1'b0;
    applyStimulus(16'h0040, 12'd8);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("t3_addr_stall", {48'd0, mem_addr_o}, 64'h50);
    checkOutput("t3_valid_stall", {63'd0, out_valid_o}, 64'd1);
    checkOutput("t3_busy_stall", {63'd0, busy_o}, 64'd1);
    checkOutput("t3_no_transfer", 64'(rx.size()), 64'd0);
    out_ready_i = 1'b1;
    waitDone(200);
    compareJob(16'h0040, 8);

    // Empty job and a start ignored while busy.
    $display("[TB] empty job and start while busy");
    d0 = doneCount;
    v0 = validSeen;
    applyStimulus(16'h1234, 12'd0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t4_done_pulses", 64'(doneCount - d0), 64'd1);
    checkOutput("t4_no_valid", 64'(validSeen - v0), 64'd0);
    checkOutput("t4_idle_busy", {63'd0, busy_o}, 64'd0);
    applyStimulus(16'h0040, 12'd2);
    @(posedge clk); #1;
    applyStimulus(16'h0000, 12'd5);
    waitDone(100);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t4_total_pulses", 64'(doneCount - d0), 64'd2);
    compareJob(16'h0040, 2);

    // Address wrap across FFFF.
    $display("[TB] job base=FFFE num=1");
    applyStimulus(16'hFFFE, 12'd1);
    checkOutput("t5_addr0", {48'd0, mem_addr_o}, 64'hFFFE);
    @(posedge clk); #1;
    checkOutput("t5_addr1", {48'd0, mem_addr_o}, 64'hFFFF);
    @(posedge clk); #1;
    checkOutput("t5_addr2", {48'd0, mem_addr_o}, 64'h0000);
    @(posedge clk); #1;
    checkOutput("t5_addr3", {48'd0, mem_addr_o}, 64'h0001);
    waitDone(100);
`ifdef BR_SIGN_CONVERT_EN
    if (rx.size() == 1) checkOutput("t5_hi_bytes", {48'd0, rx[0][31:16]}, 64'h0000);
`else
    if (rx.size() == 1) checkOutput("t5_hi_bytes", {48'd0, rx[0][31:16]}, 64'h8080);
`endif
    compareJob(16'hFFFE, 1);

    // Asynchronous reset in the middle of a fetch.
    $display("[TB] reset mid-job");
    applyStimulus(16'h0040, 12'd8);
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_addr", {48'd0, mem_addr_o}, 64'd0);
    checkOutput("t6_busy", {63'd0, busy_o}, 64'd0);
    checkOutput("t6_valid", {63'd0, out_valid_o}, 64'd0);
    checkOutput("t6_data", {32'd0, out_data_o}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    rx.delete();
    @(posedge clk); #1;
    applyStimulus(16'h0040, 12'd1);
    waitDone(100);
    compareJob(16'h0040, 1);

    // Random jobs with random backpressure.
    $display("[TB] random jobs");
    for (int j = 0; j < 8; j++) begin
      rb = 16'($urandom_range(0, 65535));
      rn = $urandom_range(1, 6);
      randomReady = 1'b1;
      applyStimulus(rb, 12'(rn));
      waitDone(600);
      compareJob(rb, rn);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
